// File: rtl/softusb_tx_pkg.sv
// Shared definitions for the softusb transmitter: state encoding, bit timing and
// line-state helpers.
package softusb_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEopSe0,
        StEopJ
    } tx_state_e;

    localparam int unsigned FS_BIT_CYCLES = 4;
    localparam int unsigned LS_BIT_CYCLES = 32;
    localparam int unsigned STUFF_LIMIT   = 6;
    localparam logic [7:0]  SYNC_BYTE     = 8'h80;

    // Down-counter reload value for one bit period.
    function automatic logic [4:0] bit_reload(input logic low_speed);
        return low_speed ? 5'(LS_BIT_CYCLES - 1) : 5'(FS_BIT_CYCLES - 1);
    endfunction

    // {txp, txm} for the J state; K is its complement.
    function automatic logic [1:0] line_j(input logic low_speed);
        return low_speed ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/softusb_tx_if.sv
// Byte handshake between the packet source and the USB transmitter.
interface softusb_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/softusb_tx_nrzi.sv
// Bit stuffing and NRZI encoding; one emitted line bit per emit strobe.
module softusb_tx_nrzi
    import softusb_tx_pkg::*;
(
    input  logic usb_clk,
    input  logic usb_rst_n,
    input  logic line_reset,
    input  logic emit,
    input  logic bit_in,
    output logic line_next,
    output logic stall
);

    logic       level_q;
    logic [2:0] stuff_q, stuff_d;

    // Six ones in a row: the next emitted bit must be a stuffed zero.
    assign stall = (stuff_q == 3'(STUFF_LIMIT));

    always_comb begin
        line_next = level_q;
        stuff_d   = stuff_q;
        if (line_reset) begin
            line_next = 1'b1;
            stuff_d   = '0;
        end else if (emit) begin
            if (stall || !bit_in) begin
                line_next = ~level_q;
                stuff_d   = '0;
            end else begin
                stuff_d = stuff_q + 3'd1;
            end
        end
    end

    // level_q = 1 means J on the line.
    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            level_q <= 1'b1;
            stuff_q <= '0;
        end else begin
            level_q <= line_next;
            stuff_q <= stuff_d;
        end
    end

endmodule

// File: rtl/softusb_tx.sv
// softusb transmitter top: bit-strobe counter, packet state machine and byte
// handshake in front of the NRZI/stuffing encoder.
module softusb_tx
    import softusb_tx_pkg::*;
(
    input  logic         usb_clk,
    input  logic         usb_rst_n,
    softusb_tx_if.slave  bus,
    input  logic         tx_low_speed,
    output logic         txp,
    output logic         txm,
    output logic         txoe,
    output logic         tx_busy
);

    tx_state_e  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] rem_q, rem_d;
    logic       speed_q, speed_d;
    logic       ready_q, ready_d;
    logic       txp_q, txp_d, txm_q, txm_d, txoe_q, txoe_d;

    logic strobe, start, shifting, emit, bit_in, line_reset, line_next, stall;

    assign strobe     = (cnt_q == 5'd0);
    assign start      = (state_q == StIdle) && bus.tx_valid;
    assign shifting   = (state_q == StSync) || (state_q == StData);
    assign line_reset = !shifting && !start;

    softusb_tx_nrzi u_nrzi (
        .usb_clk    (usb_clk),
        .usb_rst_n  (usb_rst_n),
        .line_reset (line_reset),
        .emit       (emit),
        .bit_in     (bit_in),
        .line_next  (line_next),
        .stall      (stall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = strobe ? bit_reload(speed_q) : cnt_q - 5'd1;
        sr_d    = sr_q;
        rem_d   = rem_q;
        speed_d = speed_q;
        emit    = 1'b0;
        bit_in  = sr_q[0];

        unique case (state_q)
            StIdle: begin
                cnt_d = bit_reload(tx_low_speed);
                if (bus.tx_valid) begin
                    speed_d = tx_low_speed;
                    emit    = 1'b1;
                    bit_in  = SYNC_BYTE[0];
                    sr_d    = SYNC_BYTE >> 1;
                    rem_d   = 3'd7;
                    state_d = StSync;
                end
            end
            StSync, StData: begin
                if (strobe) begin
                    if (stall) begin
                        emit = 1'b1;
                    end else if (rem_q != 3'd0) begin
                        emit  = 1'b1;
                        sr_d  = sr_q >> 1;
                        rem_d = rem_q - 3'd1;
                    end else if (ready_q) begin
                        emit    = 1'b1;
                        bit_in  = bus.tx_data[0];
                        sr_d    = bus.tx_data >> 1;
                        rem_d   = 3'd7;
                        state_d = StData;
                    end else begin
                        // rem_q counts the SE0 bit periods still to follow
                        rem_d   = 3'd1;
                        state_d = StEopSe0;
                    end
                end
            end
            StEopSe0: begin
                if (strobe) begin
                    if (rem_q != 3'd0) rem_d = rem_q - 3'd1;
                    else               state_d = StEopJ;
                end
            end
            StEopJ: begin
                if (strobe) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered ready: decided one cycle ahead of the byte-boundary strobe.
        ready_d = shifting && (cnt_q == 5'd1) && (rem_q == 3'd0) && !stall && bus.tx_valid;

        txoe_d = (state_d != StIdle);
        unique case (state_d)
            StIdle:         {txp_d, txm_d} = line_j(tx_low_speed);
            StSync, StData: {txp_d, txm_d} = line_next ? line_j(speed_d) : ~line_j(speed_d);
            StEopSe0:       {txp_d, txm_d} = 2'b00;
            StEopJ:         {txp_d, txm_d} = line_j(speed_q);
            default:        {txp_d, txm_d} = line_j(tx_low_speed);
        endcase
    end

    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            rem_q   <= '0;
            speed_q <= 1'b0;
            ready_q <= 1'b0;
            txp_q   <= 1'b1;
            txm_q   <= 1'b0;
            txoe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            speed_q <= speed_d;
            ready_q <= ready_d;
            txp_q   <= txp_d;
            txm_q   <= txm_d;
            txoe_q  <= txoe_d;
        end
    end

    assign bus.tx_ready = ready_q;
    assign txp          = txp_q;
    assign txm          = txm_q;
    assign txoe         = txoe_q;
    assign tx_busy      = txoe_q;

endmodule
